// File: rtl/sequence_generator.sv
// sequence_generator
// Serial frame transmitter. On an accepted start it emits one frame
// 0,1,0^N,1 on sig_out, one bit per enabled clock, where N is sampled from
// 'zeros' when start is accepted. Every completed frame increments a two-digit
// BCD counter (00..99, wraps), shown on two active-low 7-segment displays.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset, priority over everything
//   ena        advance enable; 0 holds every register (done included)
//   start      frame request, sampled only in IDLE with ena=1
//   zeros      N, number of middle zeros (ZW bits)
//   sig_out    registered serial output bit
//   busy       registered, high while a frame is being emitted
//   done       registered one-cycle pulse after the last frame bit
//   disp0      ones digit, active-low segments, bit0=a .. bit6=g
//   disp1      tens digit, same encoding
//   state_dbg  current FSM state code, for observation only
//
// Handshake: start is a request with no acknowledge; it is taken on an
// enabled edge while the FSM is in IDLE and ignored (not queued) otherwise.
module sequence_generator #(
  parameter int ZW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic [ZW-1:0] zeros,
  output logic          sig_out,
  output logic          busy,
  output logic          done,
  output logic [6:0]    disp0,
  output logic [6:0]    disp1,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD0 = 3'd1,
    LEAD1 = 3'd2,
    ZERO  = 3'd3,
    TAIL1 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [ZW-1:0] n_q, n_d;
  logic [ZW-1:0] rem_q, rem_d;
  logic          sig_q, sig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          frame_end;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rem_d     = rem_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD0;
          n_d     = zeros;
        end
      end
      LEAD0: state_d = LEAD1;
      LEAD1: begin
        rem_d   = n_q;
        state_d = (n_q != '0) ? ZERO : TAIL1;
      end
      ZERO: begin
        // rem_q counts the zero bits still to be emitted, this one included.
        rem_d = rem_q - ZW'(1);
        if (rem_q == ZW'(1)) state_d = TAIL1;
      end
      TAIL1: begin
        state_d   = IDLE;
        frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    sig_d  = (state_d == LEAD1) || (state_d == TAIL1);
    busy_d = (state_d != IDLE);
    done_d = frame_end;

    ones_d = ones_q;
    tens_d = tens_q;
    if (frame_end) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      rem_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else if (ena) begin
      state_q <= state_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign sig_out   = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign disp0     = seg7(ones_q);
  assign disp1     = seg7(tens_q);
  assign state_dbg = state_q;

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter: on command, emits one frame of the form 0,1,0^N,1 on a single-bit output, one bit per clock.
- N is supplied with the command.
- Drives the input of the 01[0*]1 sequence detector in board and bench setups, so each frame produces exactly one detection there.
- Counts completed frames (0..99) and shows the count on two 7-segment displays, mirroring the detector's display pair.

Parameters:
- ZW, 4, width of the zero-count field; N range is 0..2^ZW-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  advance enable; 0 freezes the FSM, the output bit and the counter.
- start  in  1  frame request; sampled only when busy=0 and ena=1.
- zeros  in  ZW  N, the number of middle zeros; latched when start is accepted.
- sig_out  out  1  serial output bit (registered).
- busy  out  1  high while a frame is being emitted.
- done  out  1  one-cycle pulse after the last frame bit.
- disp0  out  7  ones digit of the frame count, active-low segments, bit0=a .. bit6=g.
- disp1  out  7  tens digit of the frame count, same encoding.

Behaviour:
- Reset (rst=1 at an edge) has priority over everything, including mid-frame:
  - state=IDLE, sig_out=0, busy=0, done=0.
  - Latched N and remaining-zero counter cleared.
  - BCD count=00, so disp1=disp0=7'b1000000 ("0").
  - A frame in progress is abandoned; no done pulse.
- States: IDLE, LEAD0, LEAD1, ZERO, TAIL1. Three-bit encoding; unused codes go to IDLE on the next enabled edge.
- Transitions (only on edges with ena=1; with ena=0 every register holds, done included):
  - IDLE: start=1 -> LEAD0, latch N=zeros; else stay.
  - LEAD0 -> LEAD1.
  - LEAD1 -> ZERO if N>0, else TAIL1. Load remaining=N.
  - ZERO: decrement remaining; go to TAIL1 when remaining reaches 1 at that edge.
  - TAIL1 -> IDLE.
- Registered outputs by state:
  - sig_out: IDLE=0, LEAD0=0, LEAD1=1, ZERO=0, TAIL1=1.
  - busy=1 in LEAD0..TAIL1.
- Timing:
  - Start accepted at edge k: sig_out is 0 after k, 1 after k+1, 0 after k+2..k+1+N, 1 after k+2+N.
  - Back in IDLE after k+3+N.
  - Frame length is N+3 bit-cycles.
- done=1 for exactly one enabled cycle, following the TAIL1->IDLE edge. The BCD count increments on that same edge.
- start while busy=1 is ignored, not queued. The earliest next accept is the edge at which done=1 is visible (state is IDLE). Back-to-back frames are therefore separated by the one idle 0 bit.
- zeros changing mid-frame has no effect.
- Counter:
  - Two BCD digits; ones 9->0 carries into tens.
  - 99 -> 00 wrap.
- 7-segment decode:
  - Combinational from the BCD registers.
  - Digit codes (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Test Plan:
- Reset, then start=1 with zeros=0 for one cycle -> sig_out 0,1,1 on three successive cycles, then 0. busy high for 3 cycles, done pulses once, disp0=1111001.
- zeros=3 -> sig_out 0,1,0,0,0,1; busy 6 cycles. Feeding the detector gives z asserted exactly once.
- zeros=15 (max) -> 15 middle zeros, 18-cycle frame. Hold start high throughout -> next frame begins on the done cycle edge, with exactly one 0 idle bit between frames.
- ena=0 for 4 cycles mid-ZERO -> sig_out, busy and remaining frozen. Frame completes 4 cycles late with the correct bit sequence.
- rst=1 during LEAD1 -> next cycle sig_out=0, busy=0, no done, count=00. A new start then produces a full, correct frame.
- 100 frames with zeros=1 -> count passes 09->10 (disp1=1111001, disp0=1000000) and 99->00.
